// File: rtl/md_pkg.sv
// Shared op encodings, default latencies and FSM state type for the
// multiply/divide unit.
package md_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned WORD_W          = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_unit_ctrl_if.sv
// E-stage <-> multiply/divide unit bundle: op/operands in, HI/LO and
// sequencing status out.
interface md_unit_ctrl_if;
  import md_pkg::*;

  logic [2:0]        md_op;
  logic [WORD_W-1:0] A;
  logic [WORD_W-1:0] B;
  logic              rd_sel;
  logic              start;
  logic              busy;
  logic [WORD_W-1:0] HI;
  logic [WORD_W-1:0] LO;
  logic [WORD_W-1:0] rd_data;

  modport master (output md_op, A, B, rd_sel,
                  input  start, busy, HI, LO, rd_data);
  modport slave  (input  md_op, A, B, rd_sel,
                  output start, busy, HI, LO, rd_data);
endinterface

// File: rtl/md_calc.sv
// Combinational mult/div datapath; result is {hi, lo}, div0 flags a
// zero divisor so the controller can suppress the commit.
module md_calc
  import md_pkg::*;
(
  input  md_op_e            op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [63:0]       res,
  output logic              div0
);

  logic [63:0] a_sx;
  logic [63:0] b_sx;

  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};

  always_comb begin
    res  = 64'd0;
    div0 = 1'b0;
    case (op)
      // Low 64 bits of the sign-extended product equal the signed product
      MD_MULT:  res = a_sx * b_sx;
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          res = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else begin
          res = {a % b, a / b};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: fixed-latency busy window, pending result
// held until the final busy cycle, then committed into HI/LO.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  md_unit_ctrl_if.slave  md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WORD_W-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_skip_q, pend_skip_d;

  md_op_e      op;
  logic        is_calc;
  logic        is_div;
  logic        start_c;
  logic [63:0] calc_res;
  logic        calc_div0;

  assign op      = md_op_e'(md.md_op);
  assign is_calc = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign is_div  = (op == MD_DIV) || (op == MD_DIVU);
  assign start_c = is_calc && !busy_q && !reset;

  md_calc u_calc (
    .op   (op),
    .a    (md.A),
    .b    (md.B),
    .res  (calc_res),
    .div0 (calc_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_skip_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_skip_q <= pend_skip_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_skip_d = pend_skip_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d     = RUN;
          busy_d      = 1'b1;
          cnt_d       = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d   = calc_res[63:32];
          pend_lo_d   = calc_res[31:0];
          pend_skip_d = calc_div0;
        end else if (op == MD_MTHI) begin
          hi_d = md.A;
        end else if (op == MD_MTLO) begin
          lo_d = md.A;
        end
      end
      RUN: begin
        // Anything presented on md_op here is ignored by construction
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (!pend_skip_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md.start   = start_c;
  assign md.busy    = busy_q;
  assign md.HI      = hi_q;
  assign md.LO      = lo_q;
  assign md.rd_data = md.rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, arithmetic results, divide
// corner cases, collisions while busy and asynchronous reset.
module tb_md_unit_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  md_unit_ctrl_if mif ();

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: presents the op, checks start, counts busy
  // cycles, then checks committed HI/LO and the read mux.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name);
    int n;
    mif.md_op = op; mif.A = a; mif.B = b;
    #1;
    total++;
    if (mif.start !== 1'b1) begin
      bad++; $display("FAIL %s start: got %b want 1", name, mif.start);
    end
    @(negedge clk);
    mif.md_op = 3'd0;
    n = 0;
    while (mif.busy === 1'b1 && n < 50) begin
      total++;
      if (mif.rd_data === exp_lo && exp_lo !== mif.LO) begin
        bad++; $display("FAIL %s early_visible: rd_data=%h", name, mif.rd_data);
      end
      n++;
      @(negedge clk);
    end
    total++;
    if (n != exp_n) begin
      bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, n, exp_n);
    end
    total++;
    if (mif.HI !== exp_hi || mif.LO !== exp_lo) begin
      bad++; $display("FAIL %s result: got HI=%h LO=%h want HI=%h LO=%h", name, mif.HI, mif.LO, exp_hi, exp_lo);
    end
    mif.rd_sel = 1'b1;
    #1;
    total++;
    if (mif.rd_data !== exp_hi) begin
      bad++; $display("FAIL %s rd_hi: got %h want %h", name, mif.rd_data, exp_hi);
    end
    mif.rd_sel = 1'b0;
    #1;
    total++;
    if (mif.rd_data !== exp_lo) begin
      bad++; $display("FAIL %s rd_lo: got %h want %h", name, mif.rd_data, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mif.md_op = 3'd1; mif.A = 32'd3; mif.B = 32'd4; mif.rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (mif.start !== 1'b0) begin
      bad++; $display("FAIL reset_start: got %b want 0", mif.start);
    end
    total++;
    if (mif.busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) begin
      bad++; $display("FAIL reset_state: busy=%b HI=%h LO=%h want 0", mif.busy, mif.HI, mif.LO);
    end
    mif.md_op = 3'd0;
    reset = 1'b0;
  endtask

  task automatic test_mult();
    @(negedge clk);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    @(negedge clk);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, "multu");
  endtask

  task automatic test_div();
    @(negedge clk);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    @(negedge clk);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_ovf");
  endtask

  task automatic test_divu_zero();
    @(negedge clk);
    mif.md_op = 3'd5; mif.A = 32'h1234;
    #1;
    total++;
    if (mif.start !== 1'b0) begin
      bad++; $display("FAIL mthi_start: got %b want 0", mif.start);
    end
    @(negedge clk);
    total++;
    if (mif.HI !== 32'h1234 || mif.busy !== 1'b0) begin
      bad++; $display("FAIL mthi: got HI=%h busy=%b want HI=00001234 busy=0", mif.HI, mif.busy);
    end
    mif.md_op = 3'd6; mif.A = 32'h5678;
    @(negedge clk);
    total++;
    if (mif.LO !== 32'h5678 || mif.busy !== 1'b0) begin
      bad++; $display("FAIL mtlo: got LO=%h busy=%b want LO=00005678 busy=0", mif.LO, mif.busy);
    end
    mif.md_op = 3'd7;
    #1;
    total++;
    if (mif.start !== 1'b0) begin
      bad++; $display("FAIL reserved_start: got %b want 0", mif.start);
    end
    @(negedge clk);
    run_op(3'd4, 32'd5, 32'd0, 10, 32'h1234, 32'h5678, "divu_zero");
  endtask

  task automatic test_busy_collision();
    int n;
    @(negedge clk);
    mif.md_op = 3'd1; mif.A = 32'd3; mif.B = 32'd4;
    @(negedge clk);
    mif.md_op = 3'd6; mif.A = 32'hDEAD;
    #1;
    total++;
    if (mif.start !== 1'b0 || mif.busy !== 1'b1) begin
      bad++; $display("FAIL coll_mtlo: start=%b busy=%b want start=0 busy=1", mif.start, mif.busy);
    end
    @(negedge clk);
    mif.md_op = 3'd4; mif.A = 32'd100; mif.B = 32'd7;
    #1;
    total++;
    if (mif.start !== 1'b0) begin
      bad++; $display("FAIL coll_divu: start=%b want 0", mif.start);
    end
    @(negedge clk);
    mif.md_op = 3'd0;
    n = 2;
    while (mif.busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL coll_busy_cycles: got %0d want 5", n);
    end
    total++;
    if (mif.HI !== 32'd0 || mif.LO !== 32'd12) begin
      bad++; $display("FAIL coll_result: got HI=%h LO=%h want HI=00000000 LO=0000000c", mif.HI, mif.LO);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 5, 32'h1, 32'h0, "b2b_multu");
    run_op(3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, "b2b_divu");
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    mif.md_op = 3'd3; mif.A = 32'd100; mif.B = 32'd7;
    @(negedge clk);
    mif.md_op = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (mif.busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) begin
      bad++; $display("FAIL rst_mid: busy=%b HI=%h LO=%h want all 0", mif.busy, mif.HI, mif.LO);
    end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mif.busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) n++;
    end
    total++;
    if (n != 0) begin
      bad++; $display("FAIL rst_no_commit: %0d cycles with busy/HI/LO nonzero, want 0", n);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mif.md_op = 3'd0; mif.A = 32'd0; mif.B = 32'd0; mif.rd_sel = 1'b0;
    reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_divu_zero();
    test_busy_collision();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Multiply/divide unit with its sequencing controller, sitting in the E stage beside the ALU. Accepts mult/multu/div/divu/mthi/mtlo from E, models fixed multi-cycle latency with a `start`/`busy` pair, and owns the HI/LO registers. `start` and `busy` drive the hazard unit's stall rule: any md-class instruction in D freezes while `start|busy`.

## Interface

**Parameters**
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

**Ports**
- `clk` in 1: sole clock; everything rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `md_op` in 3: E-stage op. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `A` in 32: rs operand, already forwarded.
- `B` in 32: rt operand, already forwarded.
- `rd_sel` in 1: mfhi/mflo read select; 0 LO, 1 HI.
- `start` out 1: combinational; 1 when `md_op` is in 1..4 and `busy`=0.
- `busy` out 1: registered; 1 while an operation is in flight.
- `HI` out 32: committed HI register.
- `LO` out 32: committed LO register.
- `rd_data` out 32: combinational `rd_sel ? HI : LO`.

## Operation

**FSM states**
- IDLE to RUN on `start`.
- RUN to IDLE when the counter reaches 1.

**Registered state**
- `cnt`: width covers `DIV_CYCLES`.
- `pend_hi`, `pend_lo`: results waiting to commit.

**Arithmetic**, captured at the `start` edge:
- mult: signed 64-bit `A*B`. {HI,LO} = product.
- multu: unsigned 64-bit product.
- div: signed, truncating toward zero. LO = quotient, HI = remainder with the dividend's sign.
- divu: unsigned quotient/remainder.

**Division corner cases**
- B=0: the op still runs for `DIV_CYCLES` with `busy`. HI/LO are left unchanged at commit (commit suppressed).
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.

**mthi/mtlo**
- Only in IDLE. At the next edge, write A into HI or LO.
- Single cycle. No `busy`.

**Collisions with `busy`=1**
- Any `md_op` 1..6 arriving while `busy`=1 is ignored: no state change, `start`=0.
- The hazard unit prevents this case; the bench checks that it is ignored.

**Read path**
- `rd_data` shows committed HI/LO only. Pending results are never visible.

**Reset**
- Asynchronous. HI = LO = 0, `busy` = 0, `cnt` = 0, pend = 0, state IDLE.
- Reset mid-operation discards the pending result. `start` is 0 while `reset` is high.

## Timing

- Op in E during cycle t with `busy`=0: `start`=1 in cycle t.
- Edge ending cycle t: operands/results latched, `cnt` = N, `busy`=1.
- `busy`=1 for cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- Edge ending t+N: HI/LO committed, `busy`=0.
- Cycle t+N+1: `rd_data` shows the new values.
- A new `start` is allowed in cycle t+N+1. Back-to-back ops are therefore spaced N+1 cycles apart.
- mthi/mtlo in cycle t: HI/LO change at the edge ending t, visible in t+1.
- mf* with mthi/mtlo immediately before it relies on normal W-stage forwarding; this block adds no bypass.
- No combinational path from `md_op` to `busy`. The only comb outputs are `start` and `rd_data`.

## Structure

**Package `md_pkg`**
- `md_op` encodings: `MD_NONE` … `MD_MTLO`.
- Default cycle counts.
- `md_state_t` (IDLE, RUN).

**Sub-module `md_calc`**
- Purely combinational.
- Inputs: op, A, B.
- Outputs: 64-bit {hi, lo} and a `div0` flag.
- `md_unit_ctrl` holds the FSM, counter and registers, and instantiates `md_calc`.

## Test plan

1. mult A=0xFFFFFFFE (-2), B=3:
   - `start`=1 in cycle t.
   - `busy`=1 for exactly 5 cycles.
   - HI=0xFFFFFFFF, LO=0xFFFFFFFA from t+6.
2. multu A=0xFFFFFFFF, B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
3. Signed div:
   - div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
   - div 0x80000000 / -1 → LO=0x80000000, HI=0.
4. divu by zero, with HI/LO preloaded via mthi 0x1234 and mtlo 0x5678:
   - `busy` 10 cycles.
   - HI/LO unchanged afterwards.
   - mthi/mtlo themselves take effect the next cycle with `busy`=0.
5. Ops presented while busy:
   - mult issued, then mtlo and divu presented during `busy`.
   - Both ignored: `start`=0, HI/LO reflect only the mult.
6. Reset mid-operation:
   - `reset` asserted in the middle of a div's busy period.
   - `busy`, HI, LO go to 0 immediately (asynchronous).
   - After release, no commit occurs.
